router_out_arbiter: RTL

//  Per-output-port round-robin arbiter for the 8x8 serial switch. One instance sits on

---
 rtl/router_out_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/router_out_arbiter.sv
// Per-output-port round-robin arbiter for the 8x8 serial switch.
// Holds the grant for one whole packet, then releases it on packet end,
// abort or stall timeout. A dead RELEASE cycle separates consecutive grants.
module router_out_arbiter #(
    parameter int unsigned N_PORTS = 8,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_PORTS-1:0] req,
    input  logic [N_PORTS-1:0] frame_n,
    input  logic [N_PORTS-1:0] valid_n,
    output logic [N_PORTS-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic               pkt_done,
    output logic               abort,
    output logic               timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic               grant_valid_q, grant_valid_d;
    logic               pkt_done_q, pkt_done_d;
    logic               abort_q, abort_d;
    logic               timeout_q, timeout_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic               own_frame_n;
    logic               own_valid_n;

    // Round-robin search: first requester at or after rr_ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < int'(N_PORTS); k++) begin
            cand = IDX_W'((32'(rr_ptr_q) + 32'(k)) % N_PORTS);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Framing signals of the current owner
    always_comb begin
        own_frame_n = frame_n[grant_idx_q];
        own_valid_n = valid_n[grant_idx_q];
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        pkt_done_d    = 1'b0;
        abort_d       = 1'b0;
        timeout_d     = 1'b0;
        rr_ptr_d      = rr_ptr_q;
        stall_cnt_d   = stall_cnt_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d       = GRANT;
                    grant_d       = N_PORTS'(1) << win_idx;
                    grant_idx_d   = win_idx;
                    grant_valid_d = 1'b1;
                    rr_ptr_d      = (win_idx == IDX_W'(N_PORTS - 1)) ? '0 : win_idx + IDX_W'(1);
                    stall_cnt_d   = '0;
                end
            end
            GRANT: begin
                if (own_frame_n && !own_valid_n) begin
                    state_d       = RELEASE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    pkt_done_d    = 1'b1;
                end else if (own_frame_n) begin
                    state_d       = RELEASE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    abort_d       = 1'b1;
                end else if (own_valid_n) begin
                    // Release on the TIMEOUT-th consecutive stalled cycle
                    if (stall_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d       = RELEASE;
                        grant_d       = '0;
                        grant_valid_d = 1'b0;
                        timeout_d     = 1'b1;
                    end else if (stall_cnt_q != {CNT_W{1'b1}}) begin
                        stall_cnt_d = stall_cnt_q + CNT_W'(1);
                    end
                end else begin
                    stall_cnt_d = '0;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d       = IDLE;
                grant_d       = '0;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            pkt_done_q    <= 1'b0;
            abort_q       <= 1'b0;
            timeout_q     <= 1'b0;
            rr_ptr_q      <= '0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            pkt_done_q    <= pkt_done_d;
            abort_q       <= abort_d;
            timeout_q     <= timeout_d;
            rr_ptr_q      <= rr_ptr_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign pkt_done    = pkt_done_q;
    assign abort       = abort_q;
    assign timeout     = timeout_q;

endmodule
